seq_gen: RTL and testbench

Serial pattern generator: the transmit-side counterpart of the sequence detector. It loads a parallel pattern of up to WIDTH bits and shifts it out MSB-first, one bit per clock, on a single serial line `x`. The detector samples `x` on the same clock. The block can emit a pattern once or repeat it back-to-back, and it can be aborted. It is used as the stimulus source for `seq_det` in system-level runs and as a reusable serializer.

---
 rtl/seq_gen.sv | 115 +++++++++++
 tb/tb_seq_gen.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_gen.sv
`default_nettype none
// +------------------------------------------------------------------+
// | seq_gen : MSB-first serial pattern generator (single/loop/abort)  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module seq_gen #(
   parameter int WIDTH = 16,
   parameter int CW    = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] pattern,
   input  logic [CW-1:0]    len,
   input  logic             loop,
   input  logic             stop,
   output logic             x,
   output logic             x_valid,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEND   = 2'd1,
      FINISH = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [WIDTH-1:0] copy_q,  copy_d;
   logic [CW-1:0]    cnt_q,   cnt_d;
   logic [CW-1:0]    len_q,   len_d;
   logic             x_q, x_d;
   logic             x_valid_q, x_valid_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             len_ok;

   assign len_ok = (len != '0) && (len <= CW'(WIDTH));

   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      copy_d  = copy_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      case (state_q)
         IDLE: begin
            if (start && len_ok) begin
               shreg_d = pattern;
               copy_d  = pattern;
               cnt_d   = len;
               len_d   = len;
               state_d = SEND;
            end
         end
         SEND: begin
            if (cnt_q > CW'(1)) begin
               if (stop) begin
                  state_d = IDLE;
               end else begin
                  shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                  cnt_d   = cnt_q - CW'(1);
               end
            end else if (loop && !stop) begin
               // Reload on the last-bit edge so the next pass follows with no gap
               shreg_d = copy_q;
               cnt_d   = len_q;
            end else begin
               state_d = FINISH;
            end
         end
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Outputs are derived from next state so they come straight out of flops
      x_valid_d = (state_d == SEND);
      x_d       = x_valid_d & shreg_d[WIDTH-1];
      busy_d    = (state_d != IDLE);
      done_d    = (state_d == FINISH);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         shreg_q   <= '0;
         copy_q    <= '0;
         cnt_q     <= '0;
         len_q     <= '0;
         x_q       <= 1'b0;
         x_valid_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         copy_q    <= copy_d;
         cnt_q     <= cnt_d;
         len_q     <= len_d;
         x_q       <= x_d;
         x_valid_q <= x_valid_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign x       = x_q;
   assign x_valid = x_valid_q;
   assign busy    = busy_q;
   assign done    = done_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_gen.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_seq_gen : scoreboard bench for seq_gen                         |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_seq_gen;
   localparam int WIDTH = 16;
   localparam int CW    = 5;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic [WIDTH-1:0] pattern = '0;
   logic [CW-1:0]    len = '0;
   logic             loop = 1'b0;
   logic             stop = 1'b0;
   logic             x, x_valid, busy, done;

   int compared   = 0;
   int mismatched = 0;

   // expected {x, x_valid, busy, done} per cycle
   logic [3:0] sb[$];
   logic [3:0] exp_v;

   seq_gen #(.WIDTH(WIDTH), .CW(CW)) dut (
      .clk(clk), .rst(rst), .start(start), .pattern(pattern), .len(len),
      .loop(loop), .stop(stop), .x(x), .x_valid(x_valid), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic push_pass(input logic [WIDTH-1:0] p, input int l);
      for (int k = 0; k < l; k++) sb.push_back({p[WIDTH-1-k], 3'b110});
      sb.push_back(4'b0011);
      sb.push_back(4'b0000);
   endtask

   task automatic test_reset();
      #1;
      exp_v = 4'b0000;
      compared++;
      if ({x, x_valid, busy, done} !== exp_v) begin
         mismatched++;
         $display("FAIL reset_async: got %b want %b", {x, x_valid, busy, done}, exp_v);
      end
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;
      compared++;
      if ({x, x_valid, busy, done} !== exp_v) begin
         mismatched++;
         $display("FAIL reset_idle: got %b want %b", {x, x_valid, busy, done}, exp_v);
      end
   endtask

   task automatic test_single();
      pattern = 16'b0101001101101011; len = 5'd16; start = 1'b1;
      push_pass(16'b0101001101101011, 16);
      for (int c = 1; c <= 18; c++) begin
         @(posedge clk); #1;
         exp_v = sb.pop_front();
         compared++;
         if ({x, x_valid, busy, done} !== exp_v) begin
            mismatched++;
            $display("FAIL single c%0d: got %b want %b", c, {x, x_valid, busy, done}, exp_v);
         end
         start = 1'b0;
         pattern = WIDTH'($urandom);
         len = CW'($urandom_range(0, 31));
      end
   endtask

   task automatic test_short_hold();
      pattern = 16'hA000; len = 5'd3; start = 1'b1;
      push_pass(16'hA000, 3);
      void'(sb.pop_back());            // start still high: cycle 5 idle, then re-accept
      sb.push_back(4'b0000);
      push_pass(16'hA000, 3);
      for (int c = 1; c <= 10; c++) begin
         @(posedge clk); #1;
         exp_v = sb.pop_front();
         compared++;
         if ({x, x_valid, busy, done} !== exp_v) begin
            mismatched++;
            $display("FAIL short_hold c%0d: got %b want %b", c, {x, x_valid, busy, done}, exp_v);
         end
         if (c == 6) start = 1'b0;
      end
   endtask

   task automatic test_loop_stop();
      pattern = 16'hC000; len = 5'd4; loop = 1'b1; start = 1'b1;
      for (int c = 1; c <= 10; c++) sb.push_back({(((c - 1) % 4) < 2) ? 1'b1 : 1'b0, 3'b110});
      sb.push_back(4'b0000);
      sb.push_back(4'b0000);
      for (int c = 1; c <= 12; c++) begin
         @(posedge clk); #1;
         exp_v = sb.pop_front();
         compared++;
         if ({x, x_valid, busy, done} !== exp_v) begin
            mismatched++;
            $display("FAIL loop_stop2 c%0d: got %b want %b", c, {x, x_valid, busy, done}, exp_v);
         end
         start = 1'b0;
         stop = (c == 10);
      end
      start = 1'b1;
      push_pass(16'hC000, 4);
      for (int c = 1; c <= 6; c++) begin
         @(posedge clk); #1;
         exp_v = sb.pop_front();
         compared++;
         if ({x, x_valid, busy, done} !== exp_v) begin
            mismatched++;
            $display("FAIL loop_stop4 c%0d: got %b want %b", c, {x, x_valid, busy, done}, exp_v);
         end
         start = 1'b0;
         stop = (c == 4);
      end
      loop = 1'b0;
   endtask

   task automatic test_illegal();
      for (int i = 0; i < 2; i++) begin
         len = (i == 0) ? 5'd0 : 5'd17;
         pattern = 16'hFFFF;
         start = 1'b1;
         for (int c = 1; c <= 3; c++) sb.push_back(4'b0000);
         for (int c = 1; c <= 3; c++) begin
            @(posedge clk); #1;
            exp_v = sb.pop_front();
            compared++;
            if ({x, x_valid, busy, done} !== exp_v) begin
               mismatched++;
               $display("FAIL illegal len=%0d c%0d: got %b want %b", len, c, {x, x_valid, busy, done}, exp_v);
            end
         end
         start = 1'b0;
      end
   endtask

   task automatic test_busy_start();
      pattern = 16'hF0A5; len = 5'd16; start = 1'b1;
      push_pass(16'hF0A5, 16);
      for (int c = 1; c <= 18; c++) begin
         @(posedge clk); #1;
         exp_v = sb.pop_front();
         compared++;
         if ({x, x_valid, busy, done} !== exp_v) begin
            mismatched++;
            $display("FAIL busy_start c%0d: got %b want %b", c, {x, x_valid, busy, done}, exp_v);
         end
         start = (c == 5);
         if (c == 5) begin
            pattern = 16'h0000; len = 5'd3;
         end
      end
   endtask

   task automatic test_reset_mid();
      pattern = 16'b0101001101101011; len = 5'd16; start = 1'b1;
      for (int k = 0; k < 5; k++) sb.push_back({pattern[WIDTH-1-k], 3'b110});
      for (int c = 1; c <= 5; c++) begin
         @(posedge clk); #1;
         exp_v = sb.pop_front();
         compared++;
         if ({x, x_valid, busy, done} !== exp_v) begin
            mismatched++;
            $display("FAIL reset_mid pre c%0d: got %b want %b", c, {x, x_valid, busy, done}, exp_v);
         end
         start = 1'b0;
      end
      #2 rst = 1'b1;
      #1;
      exp_v = 4'b0000;
      compared++;
      if ({x, x_valid, busy, done} !== exp_v) begin
         mismatched++;
         $display("FAIL reset_mid async: got %b want %b", {x, x_valid, busy, done}, exp_v);
      end
      #1 rst = 1'b0;
      @(posedge clk); #1;
      start = 1'b1;
      push_pass(16'b0101001101101011, 16);
      for (int c = 1; c <= 18; c++) begin
         @(posedge clk); #1;
         exp_v = sb.pop_front();
         compared++;
         if ({x, x_valid, busy, done} !== exp_v) begin
            mismatched++;
            $display("FAIL reset_mid post c%0d: got %b want %b", c, {x, x_valid, busy, done}, exp_v);
         end
         start = 1'b0;
      end
   endtask

   task automatic test_back_to_back();
      for (int n = 0; n < 4; n++) begin
         int l;
         logic [WIDTH-1:0] p;
         l = (n == 0) ? 1 : int'($urandom_range(1, WIDTH));
         p = WIDTH'($urandom);
         pattern = p; len = CW'(l); start = 1'b1;
         push_pass(p, l);
         for (int c = 1; c <= l + 2; c++) begin
            @(posedge clk); #1;
            exp_v = sb.pop_front();
            compared++;
            if ({x, x_valid, busy, done} !== exp_v) begin
               mismatched++;
               $display("FAIL b2b n%0d len%0d c%0d: got %b want %b", n, l, c, {x, x_valid, busy, done}, exp_v);
            end
            start = 1'b0;
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_short_hold();
      test_loop_stop();
      test_illegal();
      test_busy_start();
      test_reset_mid();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
`default_nettype wire
